// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_PARITY  = 3'd4,
    S_STOP    = 3'd5,
    S_ACK     = 3'd6,  // reserved encoding, never entered
    S_RELEASE = 3'd7
  } ps2_tx_state_t;

  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
  localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz

  // PS/2 frames use odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
// Flops reset to 1, the idle level of an open-drain PS/2 line.
module ps2_line_sync (
  input  logic Clock_50,
  input  logic Resetn,
  input  logic line,
  output logic sync,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Resynchronise the pin and keep one extra stage for edge detection
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall_c = prev & ~sync;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop bit, then checks the device acknowledge.
// Optional watchdog from S_START through S_RELEASE: define PS2_TX_TIMEOUT_EN.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       PS2_clock,
  input  logic       PS2_data,
  input  logic [7:0] TX_data,
  input  logic       TX_start,
  output logic       TX_busy,
  output logic       TX_done,
  output logic       TX_error,
  output logic       PS2_clock_drive_low,
  output logic       PS2_data_drive_low
);

  // One counter serves the inhibit phase and the watchdog; 20 bits unless a
  // parameter is set beyond that range.
  localparam int unsigned CNT_W =
    (INHIBIT_CYCLES > 32'hF_FFFF || TIMEOUT_CYCLES > 32'hF_FFFF) ? 32 : 20;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  ps2_tx_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             parity, parity_nxt;
  logic             busy_nxt, done_nxt, error_nxt;
  logic             clk_low_nxt, data_low_nxt;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .line     (PS2_clock),
    .sync     (clk_sync),
    .fall_c   (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .line     (PS2_data),
    .sync     (data_sync),
    .fall_c   (data_fall_unused)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // State, datapath and registered outputs
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      bit_cnt             <= '0;
      shift               <= '0;
      parity              <= 1'b0;
      TX_busy             <= 1'b0;
      TX_done             <= 1'b0;
      TX_error            <= 1'b0;
      PS2_clock_drive_low <= 1'b0;
      PS2_data_drive_low  <= 1'b0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      bit_cnt             <= bit_cnt_nxt;
      shift               <= shift_nxt;
      parity              <= parity_nxt;
      TX_busy             <= busy_nxt;
      TX_done             <= done_nxt;
      TX_error            <= error_nxt;
      PS2_clock_drive_low <= clk_low_nxt;
      PS2_data_drive_low  <= data_low_nxt;
    end
  end

  // Next-state and next-output logic; data only moves after a clock fall
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    parity_nxt   = parity;
    busy_nxt     = TX_busy;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    clk_low_nxt  = PS2_clock_drive_low;
    data_low_nxt = PS2_data_drive_low;

    case (state)
      S_IDLE: begin
        busy_nxt     = 1'b0;
        clk_low_nxt  = 1'b0;
        data_low_nxt = 1'b0;
        if (TX_start) begin
          state_nxt    = S_INHIBIT;
          cnt_nxt      = '0;
          bit_cnt_nxt  = '0;
          shift_nxt    = TX_data;
          parity_nxt   = odd_parity(TX_data);
          busy_nxt     = 1'b1;
          clk_low_nxt  = 1'b1;
          data_low_nxt = (INH_LAST == '0);
        end
      end

      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_nxt    = S_START;
          cnt_nxt      = '0;
          clk_low_nxt  = 1'b0;
          data_low_nxt = 1'b1;
        end else begin
          cnt_nxt      = cnt_inc;
          data_low_nxt = (cnt_inc == INH_LAST);
        end
      end

      S_START: begin
        if (clk_fall) begin
          data_low_nxt = ~shift[0];
          shift_nxt    = {1'b0, shift[7:1]};
          bit_cnt_nxt  = BIT_W'(1);
          state_nxt    = S_DATA;
        end
      end

      S_DATA: begin
        if (clk_fall) begin
          if (bit_cnt == BIT_W'(8)) begin
            data_low_nxt = ~parity;
            state_nxt    = S_PARITY;
          end else begin
            data_low_nxt = ~shift[0];
            shift_nxt    = {1'b0, shift[7:1]};
            bit_cnt_nxt  = (bit_cnt == '1) ? bit_cnt : bit_cnt + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (clk_fall) begin
          data_low_nxt = 1'b0;
          state_nxt    = S_STOP;
        end
      end

      S_STOP: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_nxt = S_RELEASE;
          end else begin
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end

      S_RELEASE: begin
        if (clk_sync && data_sync) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        busy_nxt     = 1'b0;
        clk_low_nxt  = 1'b0;
        data_low_nxt = 1'b0;
        state_nxt    = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog: abandon the frame if the device stalls after the start bit
    if (state inside {S_START, S_DATA, S_PARITY, S_STOP, S_RELEASE}) begin
      if (cnt == TO_LAST) begin
        state_nxt    = S_IDLE;
        clk_low_nxt  = 1'b0;
        data_low_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        error_nxt    = 1'b1;
      end else begin
        cnt_nxt = cnt_inc;
      end
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model clocks frames at
// 5 us half-periods; expected results queue up at request time and a
// separate monitor pops them on every TX_done/TX_error pulse.
module tb_ps2_host_transmitter;

  localparam int unsigned INH  = 5000;
  localparam int unsigned TO   = 1000;
  localparam int unsigned HALF = 250;

  logic       Clock_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic [7:0] TX_data  = 8'h00;
  logic       TX_start = 1'b0;
  logic       TX_busy, TX_done, TX_error;
  logic       PS2_clock_drive_low, PS2_data_drive_low;
  logic       PS2_clock, PS2_data;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain wired-AND of host and device
  assign PS2_clock = ~(PS2_clock_drive_low | dev_clk_low);
  assign PS2_data  = ~(PS2_data_drive_low | dev_data_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clock_50            (Clock_50),
    .Resetn              (Resetn),
    .PS2_clock           (PS2_clock),
    .PS2_data            (PS2_data),
    .TX_data             (TX_data),
    .TX_start            (TX_start),
    .TX_busy             (TX_busy),
    .TX_done             (TX_done),
    .TX_error            (TX_error),
    .PS2_clock_drive_low (PS2_clock_drive_low),
    .PS2_data_drive_low  (PS2_data_drive_low)
  );

  always #10 Clock_50 = ~Clock_50;

  typedef struct {
    logic [9:0] frame;      // {stop, parity, data[7:0]} as seen by the device
    bit         is_error;
    bit         chk_frame;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [9:0] dev_frame = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected result
  always @(negedge Clock_50) begin
    if (Resetn && (TX_done || TX_error)) begin
      check("done_error_exclusive", 32'(TX_done & TX_error), 32'd0);
      check("busy_low_at_pulse", 32'(TX_busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse done=%0b error=%0b required=none", TX_done, TX_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_is_error", 32'(TX_error), 32'(mon_e.is_error));
        if (mon_e.chk_frame) check("frame_bits", 32'(dev_frame), 32'(mon_e.frame));
      end
    end
  end

  task automatic issue(input logic [7:0] b, input bit push, input bit is_err,
                       input logic [9:0] frame, input bit chk);
    exp_t e;
    e.frame = frame; e.is_error = is_err; e.chk_frame = chk;
    if (push) exp_q.push_back(e);
    @(negedge Clock_50);
    TX_data  = b;
    TX_start = 1'b1;
    @(negedge Clock_50);
    TX_start = 1'b0;
    check("busy_after_accept", 32'(TX_busy), 32'd1);
  endtask

  // Waits through inhibit; returns the number of cycles the clock was held low
  task automatic wait_inhibit(output int n);
    int k = 0;
    while (!PS2_clock_drive_low && k < 50) begin @(negedge Clock_50); k++; end
    check("inhibit_seen", 32'(PS2_clock_drive_low), 32'd1);
    n = 0;
    while (PS2_clock_drive_low && n < int'(INH) + 100) begin @(negedge Clock_50); n++; end
  endtask

  // Device model: 11 clock pulses, sampling data just before each rising edge
  task automatic device_frame(input bit ack, input int abort_edge);
    int n;
    wait_inhibit(n);
    check("inhibit_cycles", 32'(n), 32'(INH));
    check("start_bit_low", 32'(PS2_data_drive_low), 32'd1);
    repeat (HALF) @(negedge Clock_50);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (20) @(negedge Clock_50);
      end
      dev_clk_low = 1'b1;
      if (e == abort_edge) begin
        repeat (50) @(negedge Clock_50);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge Clock_50);
      if (e <= 10) dev_frame[e-1] = PS2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge Clock_50);
      if (e == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (TX_busy && n < 3000) begin @(negedge Clock_50); n++; end
    check(name, 32'(TX_busy), 32'd0);
    repeat (5) @(negedge Clock_50);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge Clock_50);
    // Reset state
    check("rst_busy",     32'(TX_busy), 32'd0);
    check("rst_done",     32'(TX_done), 32'd0);
    check("rst_error",    32'(TX_error), 32'd0);
    check("rst_clk_drv",  32'(PS2_clock_drive_low), 32'd0);
    check("rst_data_drv", 32'(PS2_data_drive_low), 32'd0);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock_50);

    // 1: 8'hED, bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    issue(8'hED, 1'b1, 1'b0, 10'h3ED, 1'b1);
    device_frame(1'b1, 0);
    wait_idle("t1_idle");

    // 2: 8'h01, parity 0, data released for stop bit
    issue(8'h01, 1'b1, 1'b0, 10'h201, 1'b1);
    device_frame(1'b1, 0);
    wait_idle("t2_idle");
    check("t2_data_released", 32'(PS2_data_drive_low), 32'd0);

    // 3: 8'hFF, device withholds the acknowledge
    issue(8'hFF, 1'b1, 1'b1, 10'h3FF, 1'b1);
    device_frame(1'b0, 0);
    wait_idle("t3_idle");
    check("t3_clk_released",  32'(PS2_clock_drive_low), 32'd0);
    check("t3_data_released", 32'(PS2_data_drive_low), 32'd0);

    // 4: 8'h55 requested while 8'hF4 is in flight must be dropped
    issue(8'hF4, 1'b1, 1'b0, 10'h2F4, 1'b1);
    fork
      device_frame(1'b1, 0);
      begin
        repeat (1000) @(negedge Clock_50);
        TX_data  = 8'h55;
        TX_start = 1'b1;
        @(negedge Clock_50);
        TX_start = 1'b0;
      end
    join
    wait_idle("t4_idle");
    repeat (10) @(negedge Clock_50);
    check("t4_no_second_busy", 32'(TX_busy), 32'd0);
    check("t4_no_second_clk",  32'(PS2_clock_drive_low), 32'd0);

    // 5: reset while bit 4 (0) of 8'hED is on the line
    issue(8'hED, 1'b0, 1'b0, 10'h000, 1'b0);
    device_frame(1'b1, 5);
    check("t5_bit4_driven", 32'(PS2_data_drive_low), 32'd1);
    #3 Resetn = 1'b0;
    #1;
    check("t5_rst_clk_drv",  32'(PS2_clock_drive_low), 32'd0);
    check("t5_rst_data_drv", 32'(PS2_data_drive_low), 32'd0);
    check("t5_rst_busy",     32'(TX_busy), 32'd0);
    repeat (5) @(negedge Clock_50);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock_50);
    issue(8'hED, 1'b1, 1'b0, 10'h3ED, 1'b1);
    device_frame(1'b1, 0);
    wait_idle("t5_idle");

    // 6: silent device after the start bit
`ifdef PS2_TX_TIMEOUT_EN
    issue(8'hA5, 1'b1, 1'b1, 10'h000, 1'b0);
    wait_inhibit(n);
    n = 0;
    while (!TX_error && n < 2000) begin @(negedge Clock_50); n++; end
    check("t6_timeout_cycles", 32'(n), 32'(TO));
    check("t6_data_released",  32'(PS2_data_drive_low), 32'd0);
    check("t6_clk_released",   32'(PS2_clock_drive_low), 32'd0);
    wait_idle("t6_idle");
`else
    issue(8'hA5, 1'b0, 1'b0, 10'h000, 1'b0);
    wait_inhibit(n);
    repeat (3000) @(negedge Clock_50);
    check("t6_still_busy",     32'(TX_busy), 32'd1);
    check("t6_start_bit_held", 32'(PS2_data_drive_low), 32'd1);
    Resetn = 1'b0;
    repeat (3) @(negedge Clock_50);
    Resetn = 1'b1;
    repeat (3) @(negedge Clock_50);
    check("t6_recovered", 32'(PS2_data_drive_low), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, such as LED set 8'hED or reset 8'hFF, to a keyboard or mouse using the PS/2 request-to-send sequence. It drives the open-drain clock and data lines through active-high pull-low enables and checks the device's acknowledge bit. It sits beside the PS/2 receiver on the same two pins; the top level multiplexes the tri-state pads.

Parameters:
INHIBIT_CYCLES, 5000, Clock_50 cycles the host holds PS2 clock low (100 us).
TIMEOUT_CYCLES, 750000, maximum Clock_50 cycles from start-bit release to end of acknowledge (15 ms).

Ports:
Clock_50  in  1  system clock, 50 MHz
Resetn  in  1  asynchronous, active-low reset
PS2_clock  in  1  raw PS/2 clock pin level (asynchronous)
PS2_data  in  1  raw PS/2 data pin level (asynchronous)
TX_data  in  8  byte to send; sampled when TX_start is accepted
TX_start  in  1  single-cycle request; accepted only while TX_busy=0
TX_busy  out  1  high from the cycle after acceptance until TX_done or TX_error
TX_done  out  1  1-cycle pulse: byte sent and device acknowledged
TX_error  out  1  1-cycle pulse: missing acknowledge or timeout
PS2_clock_drive_low  out  1  1 = pull clock pin to 0; 0 = release (high-Z)
PS2_data_drive_low  out  1  1 = pull data pin to 0; 0 = release (high-Z)

Behaviour:
- Reset values: all outputs 0 (both lines released), state S_IDLE, counters 0. Reset mid-frame releases both lines immediately, with no completion pulse.
- Input conditioning: PS2_clock and PS2_data each pass through a 2-FF synchronizer. Falling edge is defined as sync=0 while the previous sync value=1.
- Acceptance: on acceptance, latch TX_data into an 8-bit shift register. Latch parity = ~^TX_data (odd parity).
- S_IDLE: on TX_start, go to S_INHIBIT and clear the counter.
- S_INHIBIT: clock_drive_low=1 for exactly INHIBIT_CYCLES cycles. In the last cycle also set data_drive_low=1 (start bit). Then go to S_START.
- S_START: clock released, data held low. Wait for the first falling edge, then drive bit0 (data_drive_low = ~bit) and go to S_DATA with bit_count=1.
- S_DATA: on each falling edge, shift and drive the next bit, LSB first. After bit7 has been driven, the next falling edge drives parity and moves to S_PARITY.
- S_PARITY: next falling edge releases data (stop bit = 1) and moves to S_STOP.
- S_STOP: next falling edge (11th) samples synchronized data.
  - Data = 0: acknowledge received; go to S_RELEASE.
  - Data = 1: pulse TX_error and go to S_IDLE.
- S_RELEASE: wait until synchronized clock and data are both 1, then pulse TX_done and go to S_IDLE.
- Data changes occur only in the cycle after a detected falling edge. Data is never changed while clock is high.
- TX_start while busy is ignored. It is not queued.
- TX_busy deasserts in the same cycle as the TX_done or TX_error pulse. TX_done and TX_error are never high together.
- Bit counter is 4 bits and saturates. It cannot wrap within a frame.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- With the macro defined: a 20-bit watchdog runs in every state from S_START through S_RELEASE. When it reaches TIMEOUT_CYCLES, the block releases both lines, pulses TX_error and returns to S_IDLE. The counter clears on entering S_START.
- Without the macro: no watchdog is present. A silent device leaves the block in S_START indefinitely with data held low; only Resetn recovers it.

Decomposition:
- Package ps2_pkg holds:
  - the state enum for S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_RELEASE (S_ACK reserved, unused);
  - default constants PS2_INHIBIT_CYCLES=5000 and PS2_TIMEOUT_CYCLES=750000;
  - a parity function.
- One sub-module: ps2_line_sync, a 2-FF synchronizer plus falling-edge detector. It is instantiated twice, once for clock and once for data, and is reusable by the receiver.

Test Plan:
1. Send 8'hED with a device model ACKing at 5 us half-periods. Required response:
   - clock held low for exactly 5000 cycles;
   - bits observed at device rising edges are 0,1,0,1,1,0,1,1,1, then parity 1, then stop 1;
   - one TX_done pulse.
2. Send 8'h01. Required response: parity bit 0, data released after the 10th falling edge, TX_done asserted, TX_error=0.
3. Send 8'hFF with the device model not acknowledging (data high at the 11th falling edge). Required response: TX_error pulse, no TX_done, both drive enables 0 afterwards.
4. Pulse TX_start with 8'h55 while busy sending 8'hF4. Required response: only 8'hF4 is transmitted and a single TX_done occurs.
5. Assert Resetn low at bit 4 of 8'hED. Required response: both drive enables 0 within the same cycle, TX_busy=0, and the next request is transmitted correctly.
6. With PS2_TX_TIMEOUT_EN defined and TIMEOUT_CYCLES=1000, the device never clocks. Required response: TX_error exactly 1000 cycles after entering S_START, with data released.
